// File: rtl/cardinal_pkg.sv
// cardinal_pkg: shared packet field offsets, hop width, direction one-hots and VC encodings
// for the cardinal router input port.
package cardinal_pkg;
    localparam int PAC_W  = 64;
    localparam int HOP_W  = 4;
    localparam int F_XDIR = 1;
    localparam int F_YDIR = 2;
    localparam int F_YHOP = 8;
    localparam logic [0:4] DIR_N  = 5'b10000;
    localparam logic [0:4] DIR_S  = 5'b01000;
    localparam logic [0:4] DIR_E  = 5'b00100;
    localparam logic [0:4] DIR_W  = 5'b00010;
    localparam logic [0:4] DIR_PE = 5'b00001;
    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;
endpackage

// File: rtl/cardinal_vc_slot.sv
// cardinal_vc_slot: one virtual-channel holding slot, a full flag plus a packet register.
// A write sets full and loads data; clear only drops the full flag.
module cardinal_vc_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_wen,
    input  logic         i_clr,
    input  logic [0:W-1] i_d,
    output logic         o_full,
    output logic [0:W-1] o_q
);
    logic         r_full;
    logic [0:W-1] r_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_wen) begin
            r_full <= 1'b1;
            r_data <= i_d;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_q    = r_data;
endmodule

// File: rtl/cardinal_vc_input_port.sv
// cardinal_vc_input_port: two-VC input channel with XY routing and hop decrement on release.
// Optional CARDINAL_STALL_CNT_EN adds a saturating stall_cnt of ungranted request cycles.
module cardinal_vc_input_port #(
    parameter int PAC_WIDTH = cardinal_pkg::PAC_W,
    parameter int HOP_W     = cardinal_pkg::HOP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               polarity,
    input  logic               si,
    output logic               ri,
    input  logic [0:PAC_WIDTH-1] di,
    output logic [0:4]         sw_req,
    input  logic               sw_gnt,
`ifdef CARDINAL_STALL_CNT_EN
    output logic [0:15]        stall_cnt,
`endif
    output logic [0:PAC_WIDTH-1] sw_do
);
    import cardinal_pkg::*;

    localparam int F_XHOP = F_YHOP + HOP_W;

    logic                 w_ext, w_int, w_ifull, w_fire;
    logic                 w_full [2];
    logic [0:PAC_WIDTH-1] w_q    [2];
    logic [0:PAC_WIDTH-1] w_idata, w_do;
    logic [HOP_W-1:0]     w_xh, w_yh;

    assign w_ext   = polarity ? VC_EVEN : VC_ODD;
    assign w_int   = (w_ext == VC_EVEN) ? VC_ODD : VC_EVEN;
    assign ri      = ~w_full[w_ext];
    assign w_ifull = w_full[w_int];
    assign w_idata = w_q[w_int];
    assign w_fire  = sw_gnt && |sw_req;

    for (genvar v = 0; v < 2; v++) begin : g_slot
        cardinal_vc_slot #(.W(PAC_WIDTH)) u_slot (
            .clk    (clk),
            .reset  (reset),
            .i_wen  (si && ri && (w_ext == 1'(v))),
            .i_clr  (w_fire && (w_int == 1'(v))),
            .i_d    (di),
            .o_full (w_full[v]),
            .o_q    (w_q[v])
        );
    end

    assign w_xh = w_idata[F_XHOP +: HOP_W];
    assign w_yh = w_idata[F_YHOP +: HOP_W];

    assign sw_req = !w_ifull   ? 5'b00000 :
                    w_xh != '0 ? (w_idata[F_XDIR] ? DIR_W : DIR_E) :
                    w_yh != '0 ? (w_idata[F_YDIR] ? DIR_S : DIR_N) : DIR_PE;

    // x hops are consumed before y; a zero field is never touched so it cannot wrap
    always_comb begin
        w_do = w_idata;
        if (w_xh != '0)
            w_do[F_XHOP +: HOP_W] = w_xh - HOP_W'(1);
        else if (w_yh != '0)
            w_do[F_YHOP +: HOP_W] = w_yh - HOP_W'(1);
    end

    assign sw_do = w_ifull ? w_do : '0;

`ifdef CARDINAL_STALL_CNT_EN
    logic [0:15] r_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall <= '0;
        else if (|sw_req && !sw_gnt && r_stall != 16'hFFFF)
            r_stall <= r_stall + 16'd1;
    end

    assign stall_cnt = r_stall;
`endif
endmodule

// File: tb/tb_cardinal_vc_input_port.sv
// tb_cardinal_vc_input_port: directed vectors with hand-computed expectations for the
// cardinal input port; the router phase is driven explicitly cycle by cycle.
module tb_cardinal_vc_input_port;
    logic        clk = 1'b0;
    logic        reset, polarity, si, ri, sw_gnt;
    logic [0:63] di, sw_do;
    logic [0:4]  sw_req;
`ifdef CARDINAL_STALL_CNT_EN
    logic [0:15] stall_cnt;
`endif
    int n_vec = 0;
    int n_err = 0;

    cardinal_vc_input_port dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .si       (si),
        .ri       (ri),
        .di       (di),
        .sw_req   (sw_req),
        .sw_gnt   (sw_gnt),
`ifdef CARDINAL_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .sw_do    (sw_do)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:63] mk(input logic vc, input logic xd, input logic yd,
                                       input logic [3:0] xh, input logic [3:0] yh,
                                       input logic [47:0] pl);
        logic [0:63] p;
        p        = '0;
        p[0]     = vc;
        p[1]     = xd;
        p[2]     = yd;
        p[3:7]   = 5'b10110;
        p[8:11]  = yh;
        p[12:15] = xh;
        p[16:63] = pl;
        return p;
    endfunction

    initial begin
        reset = 1'b0; polarity = 1'b1; si = 1'b0; di = '0; sw_gnt = 1'b0;
        #2;
        check("rst_ri", 64'(ri), 64'd1);
        check("rst_req", 64'(sw_req), 64'd0);
        check("rst_do", sw_do, 64'd0);
        tick(); tick();
        reset = 1'b1;

        // x=2 east: request E, hop x decremented, grant empties the slot
        polarity = 1'b1; si = 1'b1; di = mk(0, 0, 0, 4'd2, 4'd0, 48'hA5A5_0000_1111);
        #1;
        check("t2_ri", 64'(ri), 64'd1);
        check("t2_noreq", 64'(sw_req), 64'd0);
        tick(); polarity = 1'b0; si = 1'b0; #1;
        check("t2_req_e", 64'(sw_req), 64'b00100);
        check("t2_do", sw_do, mk(0, 0, 0, 4'd1, 4'd0, 48'hA5A5_0000_1111));
        sw_gnt = 1'b1;
        tick(); sw_gnt = 1'b0; polarity = 1'b1; #1;
        check("t2_ri_after", 64'(ri), 64'd1);
        tick(); polarity = 1'b0; #1;
        check("t2_empty_req", 64'(sw_req), 64'd0);
        check("t2_empty_do", sw_do, 64'd0);

        // x=0 y=0: PE, packet unchanged
        tick(); polarity = 1'b1; si = 1'b1; di = mk(0, 1, 1, 4'd0, 4'd0, 48'h1234_5678_9ABC);
        tick(); polarity = 1'b0; si = 1'b0; #1;
        check("t3_req_pe", 64'(sw_req), 64'b00001);
        check("t3_do", sw_do, mk(0, 1, 1, 4'd0, 4'd0, 48'h1234_5678_9ABC));
        sw_gnt = 1'b1;

        // y=3 south through the odd slot
        tick(); sw_gnt = 1'b0; polarity = 1'b1;
        tick(); polarity = 1'b0; si = 1'b1; di = mk(1, 0, 1, 4'd0, 4'd3, 48'hCAFE_F00D_0001);
        #1;
        check("t4_ri", 64'(ri), 64'd1);
        tick(); polarity = 1'b1; si = 1'b0; #1;
        check("t4_req_s", 64'(sw_req), 64'b01000);
        check("t4_do", sw_do, mk(1, 0, 1, 4'd0, 4'd2, 48'hCAFE_F00D_0001));
        sw_gnt = 1'b1;

        // fill both slots, no grants: writes blocked and data held
        tick(); sw_gnt = 1'b0; polarity = 1'b0; si = 1'b1; di = mk(1, 1, 0, 4'd0, 4'd1, 48'h0000_0000_BBBB);
        tick(); polarity = 1'b1; di = mk(0, 1, 0, 4'd1, 4'd0, 48'h0000_0000_AAAA);
        tick(); polarity = 1'b0; di = 64'hDEAD_BEEF_DEAD_BEEF; #1;
        check("t5_ri_p0", 64'(ri), 64'd0);
        check("t5_req_w", 64'(sw_req), 64'b00010);
        check("t5_do_even", sw_do, mk(0, 1, 0, 4'd0, 4'd0, 48'h0000_0000_AAAA));
        tick(); polarity = 1'b1; #1;
        check("t5_ri_p1", 64'(ri), 64'd0);
        check("t5_req_n", 64'(sw_req), 64'b10000);
        check("t5_do_odd", sw_do, mk(1, 1, 0, 4'd0, 4'd0, 48'h0000_0000_BBBB));
        tick(); polarity = 1'b0; si = 1'b0; #1;
        check("t5_do_even2", sw_do, mk(0, 1, 0, 4'd0, 4'd0, 48'h0000_0000_AAAA));
        sw_gnt = 1'b1;

        // same edge: write even while the odd slot is granted
        tick(); polarity = 1'b1; si = 1'b1; di = mk(0, 1, 0, 4'd3, 4'd0, 48'h0000_0000_CCCC); #1;
        check("t6_ri", 64'(ri), 64'd1);
        check("t6_req_n", 64'(sw_req), 64'b10000);
        tick(); sw_gnt = 1'b0; si = 1'b0; polarity = 1'b0; #1;
        check("t6_req_w", 64'(sw_req), 64'b00010);
        check("t6_do", sw_do, mk(0, 1, 0, 4'd2, 4'd0, 48'h0000_0000_CCCC));
        check("t6_ri_odd", 64'(ri), 64'd1);

        // asynchronous reset mid-traffic, checked before any clock edge
        #1 reset = 1'b0;
        #1;
        check("t1_ri", 64'(ri), 64'd1);
        check("t1_req", 64'(sw_req), 64'd0);
        check("t1_do", sw_do, 64'd0);
`ifdef CARDINAL_STALL_CNT_EN
        check("t1_stall", 64'(stall_cnt), 64'd0);
`endif
        tick(); tick();
        reset = 1'b1;

        // both slots full, five ungranted request cycles
        polarity = 1'b1; si = 1'b1; di = mk(0, 1, 0, 4'd1, 4'd0, 48'h0000_0000_0001);
        tick(); polarity = 1'b0; di = mk(1, 0, 0, 4'd0, 4'd1, 48'h0000_0000_0002);
        tick(); polarity = 1'b1; si = 1'b0;
        tick(); polarity = 1'b0;
        tick(); polarity = 1'b1;
        tick(); polarity = 1'b0;
        tick(); polarity = 1'b1; #1;
        check("st_req_n", 64'(sw_req), 64'b10000);
`ifdef CARDINAL_STALL_CNT_EN
        check("st_cnt5", 64'(stall_cnt), 64'd5);
`endif
        sw_gnt = 1'b1;
        tick(); sw_gnt = 1'b0; polarity = 1'b0; #1;
`ifdef CARDINAL_STALL_CNT_EN
        check("st_cnt_hold", 64'(stall_cnt), 64'd5);
`endif
        check("st_req_w", 64'(sw_req), 64'b00010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
